// File: rtl/sa4_cache_pkg.sv
// Shared widths, field-extract helpers and types for the 4-way cache lookup path.
package sa4_cache_pkg;

  localparam int unsigned CacheLines    = 256;
  localparam int unsigned LineSizeBytes = 64;
  localparam int unsigned DataWidth     = 32;
  localparam int unsigned AddressWidth  = 32;
  localparam int unsigned Ways          = 4;

  localparam int unsigned OffsetW      = $clog2(LineSizeBytes);
  localparam int unsigned IndexW       = $clog2(CacheLines);
  localparam int unsigned TagW         = AddressWidth - IndexW - OffsetW;
  localparam int unsigned LineW        = LineSizeBytes * 8;
  localparam int unsigned ByteW        = $clog2(DataWidth / 8);
  localparam int unsigned WordsPerLine = LineSizeBytes / (DataWidth / 8);
  localparam int unsigned WordW        = $clog2(WordsPerLine);

  typedef logic [1:0]              way_t;
  typedef logic [AddressWidth-1:0] addr_t;
  typedef logic [TagW-1:0]         tag_t;
  typedef logic [IndexW-1:0]       index_t;
  typedef logic [WordW-1:0]        word_idx_t;
  typedef logic [LineW-1:0]        line_t;
  typedef logic [DataWidth-1:0]    data_t;

  function automatic tag_t get_tag(input addr_t a);
    return a[AddressWidth-1 -: TagW];
  endfunction

  function automatic index_t get_index(input addr_t a);
    return a[OffsetW +: IndexW];
  endfunction

  // Sub-word byte bits are dropped: accesses are always word aligned.
  function automatic word_idx_t get_word(input addr_t a);
    return a[ByteW +: WordW];
  endfunction

endpackage

// File: rtl/sa4_way_hit_select_if.sv
// Load-port and fill-port bundle between the core/refill side and the cache lookup block.
interface sa4_way_hit_select_if;
  import sa4_cache_pkg::*;

  logic   i_lookup;
  addr_t  i_address;
  logic   i_fill_en;
  addr_t  i_fill_addr;
  way_t   i_fill_way;
  line_t  i_fill_line;
  data_t  o_data;
  logic   o_cache_hit;
  way_t   o_hit_way;
  logic   o_valid;

  modport master (
    output i_lookup, i_address, i_fill_en, i_fill_addr, i_fill_way, i_fill_line,
    input  o_data, o_cache_hit, o_hit_way, o_valid
  );

  modport slave (
    input  i_lookup, i_address, i_fill_en, i_fill_addr, i_fill_way, i_fill_line,
    output o_data, o_cache_hit, o_hit_way, o_valid
  );

endinterface

// File: rtl/sa4_way_match.sv
// Single-way hit detect: stored tag matches the lookup tag and the way is valid.
module sa4_way_match
  import sa4_cache_pkg::*;
(
  input  tag_t i_tag_a,
  input  tag_t i_tag_b,
  input  logic i_valid,
  output logic o_match
);

  assign o_match = i_valid & (i_tag_a == i_tag_b);

endmodule

// File: rtl/sa4_way_hit_select.sv
// 4-way set-associative read lookup with line fill port and registered word output.
module sa4_way_hit_select
  import sa4_cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  sa4_way_hit_select_if.slave   bus
);

  logic [CacheLines-1:0][Ways-1:0] valid_q;
  tag_t                            tag_q  [CacheLines][Ways];
  line_t                           data_q [CacheLines][Ways];

  tag_t      lk_tag;
  index_t    lk_idx;
  word_idx_t lk_word;
  index_t    fill_idx;

  logic [Ways-1:0] hit;
  logic [Ways-1:0] sel;
  line_t           line_sel;
  data_t           word_sel;
  way_t            way_sel;

  assign lk_tag   = get_tag(bus.i_address);
  assign lk_idx   = get_index(bus.i_address);
  assign lk_word  = get_word(bus.i_address);
  assign fill_idx = get_index(bus.i_fill_addr);

  for (genvar w = 0; w < Ways; w++) begin : g_way
    sa4_way_match u_match (
      .i_tag_a (tag_q[lk_idx][w]),
      .i_tag_b (lk_tag),
      .i_valid (valid_q[lk_idx][w]),
      .o_match (hit[w])
    );
  end

  // Isolate the lowest set bit so a corrupt multi-hit still yields a one-hot select.
  assign sel = hit & (~hit + 1'b1);

  always_comb begin
    line_sel = '0;
    way_sel  = '0;
    word_sel = '0;
    for (int w = 0; w < Ways; w++) begin
      line_sel = line_sel | ({LineW{sel[w]}} & data_q[lk_idx][w]);
      way_sel  = way_sel | ({2{sel[w]}} & way_t'(w));
    end
    for (int k = 0; k < WordsPerLine; k++) begin
      word_sel = word_sel | ({DataWidth{lk_word == word_idx_t'(k)}} & line_sel[k*DataWidth +: DataWidth]);
    end
  end

  // Valid bits and result registers: the only state cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q         <= '0;
      bus.o_data      <= '0;
      bus.o_cache_hit <= 1'b0;
      bus.o_hit_way   <= '0;
      bus.o_valid     <= 1'b0;
    end else begin
      if (bus.i_fill_en) begin
        valid_q[fill_idx][bus.i_fill_way] <= 1'b1;
      end
      bus.o_valid <= bus.i_lookup;
      if (bus.i_lookup) begin
        bus.o_data      <= word_sel;
        bus.o_cache_hit <= |hit;
        bus.o_hit_way   <= way_sel;
      end
    end
  end

  // Tag/data arrays carry no reset; the read above sees pre-fill contents.
  always_ff @(posedge clk) begin
    if (rst && bus.i_fill_en) begin
      tag_q[fill_idx][bus.i_fill_way]  <= get_tag(bus.i_fill_addr);
      data_q[fill_idx][bus.i_fill_way] <= bus.i_fill_line;
    end
  end

endmodule

// File: tb/tb_sa4_way_hit_select.sv
// Directed bench for the 4-way cache lookup path with hand-computed expectations.
module tb_sa4_way_hit_select;
  import sa4_cache_pkg::*;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  sa4_way_hit_select_if bus ();

  sa4_way_hit_select dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic line_t make_line(input logic [31:0] base);
    line_t l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = base + 32'(k);
    return l;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic h,
                           input logic [1:0] w, input logic [31:0] d);
    check({tag, ".valid"}, 32'(bus.o_valid), 32'(v));
    check({tag, ".hit"},   32'(bus.o_cache_hit), 32'(h));
    check({tag, ".way"},   32'(bus.o_hit_way), 32'(w));
    check({tag, ".data"},  bus.o_data, d);
  endtask

  // One clock; inputs return to idle #1 after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    bus.i_lookup  = 1'b0;
    bus.i_fill_en = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] a);
    bus.i_lookup  = 1'b1;
    bus.i_address = a;
    step();
  endtask

  task automatic fill(input logic [31:0] a, input logic [1:0] w, input line_t l);
    bus.i_fill_en   = 1'b1;
    bus.i_fill_addr = a;
    bus.i_fill_way  = w;
    bus.i_fill_line = l;
    step();
  endtask

  line_t l2;

  initial begin
    n_assert        = 0;
    n_fail          = 0;
    rst             = 1'b0;
    bus.i_lookup    = 1'b0;
    bus.i_address   = '0;
    bus.i_fill_en   = 1'b0;
    bus.i_fill_addr = '0;
    bus.i_fill_way  = '0;
    bus.i_fill_line = '0;
    step();
    step();
    check_out("reset", 1'b0, 1'b0, 2'd0, 32'h0);
    rst = 1'b1;

    lookup(32'h1234_5678);
    check_out("cold_miss", 1'b1, 1'b0, 2'd0, 32'h0);

    l2 = make_line(32'h2200_0000);
    l2[14*32 +: 32] = 32'hDEAD_BEEF;
    fill(32'h1234_5640, 2'd2, l2);
    lookup(32'h1234_5678);
    check_out("hit_way2", 1'b1, 1'b1, 2'd2, 32'hDEAD_BEEF);

    // Way0 gets the same tag as way2 (multi-hit); way3 tag 1 in set 0x59.
    fill(32'h1234_5640, 2'd0, make_line(32'h1100_0000));
    fill(32'h0000_5640, 2'd3, make_line(32'h3300_0000));
    lookup(32'h0000_5678);
    check_out("hit_way3", 1'b1, 1'b1, 2'd3, 32'h3300_000E);
    lookup(32'h0000_9678);
    check_out("miss_tag2", 1'b1, 1'b0, 2'd0, 32'h0);
    lookup(32'h1234_5678);
    check_out("multi_hit", 1'b1, 1'b1, 2'd0, 32'h1100_000E);

    // Fill and lookup same set/way in one cycle: lookup sees old contents.
    bus.i_lookup  = 1'b1;
    bus.i_address = 32'h0000_C404;
    fill(32'h0000_C400, 2'd1, make_line(32'h4400_0000));
    check_out("rbw_miss", 1'b1, 1'b0, 2'd0, 32'h0);
    lookup(32'h0000_C404);
    check_out("rbw_hit", 1'b1, 1'b1, 2'd1, 32'h4400_0001);
    step();
    check_out("idle_hold", 1'b0, 1'b1, 2'd1, 32'h4400_0001);

    fill(32'h0001_4800, 2'd1, make_line(32'h5500_0000));
    lookup(32'h0001_4800);
    check_out("pre_rst_hit", 1'b1, 1'b1, 2'd1, 32'h5500_0000);
    // Reset cycle also carries a fill and a lookup; both are discarded.
    rst           = 1'b0;
    bus.i_lookup  = 1'b1;
    bus.i_address = 32'h0001_4800;
    fill(32'h0001_4840, 2'd2, make_line(32'h6600_0000));
    check_out("rst_mid", 1'b0, 1'b0, 2'd0, 32'h0);
    rst = 1'b1;
    lookup(32'h0001_4800);
    check_out("post_rst_miss", 1'b1, 1'b0, 2'd0, 32'h0);
    lookup(32'h0001_4840);
    check_out("rst_fill_drop", 1'b1, 1'b0, 2'd0, 32'h0);

    fill(32'h1234_5640, 2'd0, make_line(32'hC0DE_0000));
    lookup(32'h1234_5640);
    check_out("off_00", 1'b1, 1'b1, 2'd0, 32'hC0DE_0000);
    lookup(32'h1234_567C);
    check_out("off_3c", 1'b1, 1'b1, 2'd0, 32'hC0DE_000F);
    lookup(32'h1234_567F);
    check_out("off_3f", 1'b1, 1'b1, 2'd0, 32'hC0DE_000F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
